// File: rtl/baccarat_round_engine_if.sv
`default_nettype none
// ============================================================================
// baccarat_round_engine_if : dealer/step inputs and display-side outputs
// Rev 1.0
// ============================================================================
interface baccarat_round_engine_if #(
  parameter int TALLY_W = 8
);
  logic               step;
  logic               auto;
  logic [3:0]         new_card;
  logic               card_req;
  logic               card_err;
  logic [11:0]        pcards;
  logic [11:0]        dcards;
  logic [3:0]         pscore;
  logic [3:0]         dscore;
  logic               player_win;
  logic               dealer_win;
  logic [TALLY_W-1:0] p_tally;
  logic [TALLY_W-1:0] d_tally;
  logic [TALLY_W-1:0] t_tally;
  logic [3:0]         state;

  modport master (
    output step, auto, new_card,
    input  card_req, card_err, pcards, dcards, pscore, dscore,
           player_win, dealer_win, p_tally, d_tally, t_tally, state
  );

  modport slave (
    input  step, auto, new_card,
    output card_req, card_err, pcards, dcards, pscore, dscore,
           player_win, dealer_win, p_tally, d_tally, t_tally, state
  );
endinterface
`default_nettype wire

// File: rtl/baccarat_round_engine.sv
`default_nettype none
// ============================================================================
// baccarat_round_engine : baccarat round FSM, hand scoring and win tallies
// Rev 1.0
// ============================================================================
module baccarat_round_engine #(
  parameter int TALLY_W  = 8,
  parameter int AUTO_DIV = 25_000_000
) (
  input  wire logic              CLOCK_50,
  input  wire logic              reset,
  baccarat_round_engine_if.slave bus
);

  localparam int c_cnt_w = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(AUTO_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DP1    = 4'd1,
    S_DD1    = 4'd2,
    S_DP2    = 4'd3,
    S_DD2    = 4'd4,
    S_CHECK  = 4'd5,
    S_DP3    = 4'd6,
    S_DD3    = 4'd7,
    S_RESULT = 4'd8,
    S_HOLD   = 4'd9
  } state_t;

  state_t             r_state;
  logic [3:0]         r_p1, r_p2, r_p3, r_d1, r_d2, r_d3;
  logic               r_card_req, r_card_err;
  logic               r_pwin, r_dwin;
  logic [TALLY_W-1:0] r_pt, r_dt, r_tt;
  logic [c_cnt_w-1:0] r_cnt;

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= 4'd10) ? 4'd0 : c;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    if (s >= 5'd20)      return 4'(s - 5'd20);
    else if (s >= 5'd10) return 4'(s - 5'd10);
    else                 return s[3:0];
  endfunction

  logic [3:0] w_pscore, w_dscore, w_nv;
  logic       w_card_ok, w_wrap, w_adv, w_bank_draw;

  assign w_pscore  = mod10(5'(card_val(r_p1)) + 5'(card_val(r_p2)) + 5'(card_val(r_p3)));
  assign w_dscore  = mod10(5'(card_val(r_d1)) + 5'(card_val(r_d2)) + 5'(card_val(r_d3)));
  assign w_card_ok = (bus.new_card != 4'd0) && (bus.new_card <= 4'd13);
  assign w_nv      = card_val(bus.new_card);
  assign w_wrap    = bus.auto && (r_cnt == c_cnt_max);
  assign w_adv     = bus.auto ? w_wrap : bus.step;

  // Banker's response to the player's third card, evaluated while it is being dealt
  always_comb begin
    w_bank_draw = 1'b0;
    case (w_dscore)
      4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
      4'd3:             w_bank_draw = (w_nv != 4'd8);
      4'd4:             w_bank_draw = (w_nv >= 4'd2) && (w_nv <= 4'd7);
      4'd5:             w_bank_draw = (w_nv >= 4'd4) && (w_nv <= 4'd7);
      4'd6:             w_bank_draw = (w_nv == 4'd6) || (w_nv == 4'd7);
      default:          w_bank_draw = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                      r_cnt <= '0;
    else if (!bus.auto || w_wrap)   r_cnt <= '0;
    else                            r_cnt <= r_cnt + c_cnt_w'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      {r_p1, r_p2, r_p3, r_d1, r_d2, r_d3} <= '0;
      r_card_req <= 1'b0;
      r_card_err <= 1'b0;
      r_pwin     <= 1'b0;
      r_dwin     <= 1'b0;
      r_pt       <= '0;
      r_dt       <= '0;
      r_tt       <= '0;
    end else begin
      r_card_req <= 1'b0;
      r_card_err <= 1'b0;
      if (w_adv) begin
        case (r_state)
          S_IDLE: r_state <= S_DP1;
          S_DP1, S_DD1, S_DP2, S_DD2, S_DP3, S_DD3: begin
            if (!w_card_ok) begin
              r_card_err <= 1'b1;
            end else begin
              r_card_req <= 1'b1;
              case (r_state)
                S_DP1:   begin r_p1 <= bus.new_card; r_state <= S_DD1; end
                S_DD1:   begin r_d1 <= bus.new_card; r_state <= S_DP2; end
                S_DP2:   begin r_p2 <= bus.new_card; r_state <= S_DD2; end
                S_DD2:   begin r_d2 <= bus.new_card; r_state <= S_CHECK; end
                S_DP3:   begin
                  r_p3    <= bus.new_card;
                  r_state <= w_bank_draw ? S_DD3 : S_RESULT;
                end
                default: begin r_d3 <= bus.new_card; r_state <= S_RESULT; end
              endcase
            end
          end
          S_CHECK: begin
            if (w_pscore >= 4'd8 || w_dscore >= 4'd8) r_state <= S_RESULT;
            else if (w_pscore <= 4'd5)                r_state <= S_DP3;
            else if (w_dscore <= 4'd5)                r_state <= S_DD3;
            else                                      r_state <= S_RESULT;
          end
          S_RESULT: begin
            r_pwin <= (w_pscore >= w_dscore);
            r_dwin <= (w_dscore >= w_pscore);
            // Tallies stick at all-ones rather than wrapping
            if (w_pscore > w_dscore) begin
              if (r_pt != '1) r_pt <= r_pt + TALLY_W'(1);
            end else if (w_dscore > w_pscore) begin
              if (r_dt != '1) r_dt <= r_dt + TALLY_W'(1);
            end else begin
              if (r_tt != '1) r_tt <= r_tt + TALLY_W'(1);
            end
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            {r_p1, r_p2, r_p3, r_d1, r_d2, r_d3} <= '0;
            r_pwin  <= 1'b0;
            r_dwin  <= 1'b0;
            r_state <= S_DP1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.card_req   = r_card_req;
  assign bus.card_err   = r_card_err;
  assign bus.pcards     = {r_p3, r_p2, r_p1};
  assign bus.dcards     = {r_d3, r_d2, r_d1};
  assign bus.pscore     = w_pscore;
  assign bus.dscore     = w_dscore;
  assign bus.player_win = r_pwin;
  assign bus.dealer_win = r_dwin;
  assign bus.p_tally    = r_pt;
  assign bus.d_tally    = r_dt;
  assign bus.t_tally    = r_tt;
  assign bus.state      = r_state;

endmodule
`default_nettype wire
